// File: rtl/surf5_wbm_arbiter.sv
// surf5_wbm_arbiter: two-master Wishbone arbiter (round-robin, lock, bus watchdog)
// Shares the WBC bus between the control master (m0) and the VIO bridge (m1).
module surf5_wbm_arbiter #(
    parameter int DAT_W   = 32,
    parameter int ADR_W   = 20,
    parameter int SEL_W   = 4,
    parameter int TMO_CYC = 255
) (
    input  logic             wbc_clk_i,
    input  logic             rst_n_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic             m0_lock_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic             m0_rty_o,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic             m1_lock_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             m1_rty_o,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [ADR_W-1:0] adr_o,
    output logic [DAT_W-1:0] dat_o,
    output logic [SEL_W-1:0] sel_o,
    input  logic [DAT_W-1:0] dat_i,
    input  logic             ack_i,
    input  logic             err_i,
    input  logic             rty_i,
    output logic [1:0]       grant_o,
    output logic             timeout_o,
    output logic [15:0]      timeout_cnt_o
);
    typedef enum logic [2:0] {IDLE, OWN0, OWN1, ABORT0, ABORT1} state_t;

    state_t      state, state_nxt;
    logic        last, own0, own1, sel1, stall, tmo;
    logic [15:0] wdt;

    assign own0 = state == OWN0;
    assign own1 = state == OWN1;
    assign sel1 = own1 || state == ABORT1;

    assign cyc_o = own0 ? m0_cyc_i : own1 ? m1_cyc_i : 1'b0;
    assign stb_o = own0 ? m0_stb_i : own1 ? m1_stb_i : 1'b0;
    assign we_o  = own0 ? m0_we_i  : own1 ? m1_we_i  : 1'b0;
    assign adr_o = sel1 ? m1_adr_i : m0_adr_i;
    assign dat_o = sel1 ? m1_dat_i : m0_dat_i;
    assign sel_o = sel1 ? m1_sel_i : m0_sel_i;

    // A termination in the limit cycle wins over the watchdog
    assign stall = (own0 || own1) && stb_o && !(ack_i || err_i || rty_i);
    assign tmo   = stall && wdt == 16'(TMO_CYC - 1);

    assign m0_dat_o = dat_i;
    assign m1_dat_o = dat_i;
    assign m0_ack_o = own0 && ack_i;
    assign m0_err_o = own0 && (err_i || tmo);
    assign m0_rty_o = own0 && rty_i;
    assign m1_ack_o = own1 && ack_i;
    assign m1_err_o = own1 && (err_i || tmo);
    assign m1_rty_o = own1 && rty_i;

    assign grant_o   = {sel1, own0 || state == ABORT0};
    assign timeout_o = tmo;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = m0_cyc_i && (!m1_cyc_i || last) ? OWN0 : m1_cyc_i ? OWN1 : IDLE;
            OWN0:    state_nxt = tmo ? ABORT0 : !m0_cyc_i && !m0_lock_i ? IDLE : OWN0;
            OWN1:    state_nxt = tmo ? ABORT1 : !m1_cyc_i && !m1_lock_i ? IDLE : OWN1;
            ABORT0:  state_nxt = m0_cyc_i ? ABORT0 : IDLE;
            ABORT1:  state_nxt = m1_cyc_i ? ABORT1 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wbc_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            last          <= 1'b1;
            wdt           <= '0;
            timeout_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt != IDLE)
                last <= state_nxt == OWN1;
            wdt <= stall && !tmo ? wdt + 16'd1 : 16'd0;
            if (tmo && timeout_cnt_o != 16'hFFFF)
                timeout_cnt_o <= timeout_cnt_o + 16'd1;
        end
    end
endmodule

// File: tb/tb_surf5_wbm_arbiter.sv
// tb_surf5_wbm_arbiter: directed vector table plus watchdog/reset sequences
// Watchdog limit shortened to 8 cycles so abort paths are reachable quickly.
module tb_surf5_wbm_arbiter;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        m0_cyc, m0_stb, m0_we, m0_lock, m1_cyc, m1_stb, m1_we, m1_lock;
    logic [19:0] m0_adr, m1_adr, adr_o;
    logic [31:0] m0_dat, m1_dat, m0_dat_o, m1_dat_o, dat_o, dat_i;
    logic [3:0]  m0_sel, m1_sel, sel_o;
    logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
    logic        cyc_o, stb_o, we_o, ack_i, err_i, rty_i, timeout_o;
    logic [1:0]  grant_o;
    logic [15:0] timeout_cnt_o;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    surf5_wbm_arbiter #(.DAT_W(32), .ADR_W(20), .SEL_W(4), .TMO_CYC(8)) dut (
        .wbc_clk_i(clk), .rst_n_i(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_lock_i(m0_lock),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_lock_i(m1_lock),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
        .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i),
        .grant_o(grant_o), .timeout_o(timeout_o), .timeout_cnt_o(timeout_cnt_o)
    );

    // in = {m0 cyc,stb,lock, m1 cyc,stb,lock, ack,err,rty}; term = {a0,a1,e0,e1,r0,r1}
    typedef struct packed {
        logic [8:0] in;
        logic [1:0] g;
        logic [1:0] cs;
        logic [5:0] term;
    } vec_t;

    vec_t tbl [0:45];

    task automatic set_in(input logic [8:0] v);
        {m0_cyc, m0_stb, m0_lock, m1_cyc, m1_stb, m1_lock, ack_i, err_i, rty_i} = v;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        tbl = '{
            {9'b000_000_000, 2'b00, 2'b00, 6'b000000},
            {9'b110_000_000, 2'b00, 2'b00, 6'b000000},
            {9'b110_000_000, 2'b01, 2'b11, 6'b000000},
            {9'b110_000_100, 2'b01, 2'b11, 6'b100000},
            {9'b000_000_000, 2'b01, 2'b00, 6'b000000},
            {9'b000_000_111, 2'b00, 2'b00, 6'b000000},
            {9'b110_110_000, 2'b00, 2'b00, 6'b000000},
            {9'b110_110_100, 2'b10, 2'b11, 6'b010000},
            {9'b110_000_000, 2'b10, 2'b00, 6'b000000},
            {9'b110_110_000, 2'b00, 2'b00, 6'b000000},
            {9'b110_110_100, 2'b01, 2'b11, 6'b100000},
            {9'b000_110_000, 2'b01, 2'b00, 6'b000000},
            {9'b110_110_000, 2'b00, 2'b00, 6'b000000},
            {9'b110_110_100, 2'b10, 2'b11, 6'b010000},
            {9'b110_000_000, 2'b10, 2'b00, 6'b000000},
            {9'b110_110_000, 2'b00, 2'b00, 6'b000000},
            {9'b110_110_100, 2'b01, 2'b11, 6'b100000},
            {9'b000_110_000, 2'b01, 2'b00, 6'b000000},
            {9'b110_110_000, 2'b00, 2'b00, 6'b000000},
            {9'b110_110_100, 2'b10, 2'b11, 6'b010000},
            {9'b110_000_000, 2'b10, 2'b00, 6'b000000},
            {9'b110_110_000, 2'b00, 2'b00, 6'b000000},
            {9'b110_110_100, 2'b01, 2'b11, 6'b100000},
            {9'b000_110_000, 2'b01, 2'b00, 6'b000000},
            {9'b110_110_000, 2'b00, 2'b00, 6'b000000},
            {9'b110_110_100, 2'b10, 2'b11, 6'b010000},
            {9'b110_000_000, 2'b10, 2'b00, 6'b000000},
            {9'b110_000_000, 2'b00, 2'b00, 6'b000000},
            {9'b110_000_100, 2'b01, 2'b11, 6'b100000},
            {9'b000_000_000, 2'b01, 2'b00, 6'b000000},
            {9'b000_000_000, 2'b00, 2'b00, 6'b000000},
            {9'b110_111_000, 2'b00, 2'b00, 6'b000000},
            {9'b110_111_100, 2'b10, 2'b11, 6'b010000},
            {9'b110_001_000, 2'b10, 2'b00, 6'b000000},
            {9'b110_111_100, 2'b10, 2'b11, 6'b010000},
            {9'b110_001_000, 2'b10, 2'b00, 6'b000000},
            {9'b110_111_010, 2'b10, 2'b11, 6'b000100},
            {9'b110_101_000, 2'b10, 2'b10, 6'b000000},
            {9'b110_000_000, 2'b10, 2'b00, 6'b000000},
            {9'b110_000_000, 2'b00, 2'b00, 6'b000000},
            {9'b110_000_010, 2'b01, 2'b11, 6'b001000},
            {9'b110_000_001, 2'b01, 2'b11, 6'b000010},
            {9'b110_000_100, 2'b01, 2'b11, 6'b100000},
            {9'b000_000_000, 2'b01, 2'b00, 6'b000000},
            {9'b001_000_000, 2'b00, 2'b00, 6'b000000},
            {9'b000_000_000, 2'b00, 2'b00, 6'b000000}
        };
        m0_we = 1'b1; m0_adr = 20'h00010; m0_dat = 32'h1111_2222; m0_sel = 4'hF;
        m1_we = 1'b0; m1_adr = 20'h0ABCD; m1_dat = 32'h3333_4444; m1_sel = 4'h3;
        dat_i = 32'hCAFE_F00D;
        set_in(9'b110_110_111);
        repeat (2) @(negedge clk);
        #1;
        chk("reset grant", 32'(grant_o), 32'h0);
        chk("reset cyc/stb/we", 32'({cyc_o, stb_o, we_o}), 32'h0);
        chk("reset terms", 32'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}), 32'h0);
        chk("reset tcnt", 32'(timeout_cnt_o), 32'h0);
        chk("reset timeout", 32'(timeout_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 46; i++) begin
            set_in(tbl[i].in);
            #1;
            chk($sformatf("row%0d grant", i), 32'(grant_o), 32'(tbl[i].g));
            chk($sformatf("row%0d cyc/stb", i), 32'({cyc_o, stb_o}), 32'(tbl[i].cs));
            chk($sformatf("row%0d terms", i),
                32'({m0_ack, m1_ack, m0_err, m1_err, m0_rty, m1_rty}), 32'(tbl[i].term));
            chk($sformatf("row%0d dat_o", i), m0_dat_o ^ m1_dat_o ^ 32'(timeout_o), 32'h0);
            if (tbl[i].g == 2'b01)
                chk($sformatf("row%0d m0 bus", i), {adr_o[11:0], dat_o[15:0], sel_o}, 32'h0102222F);
            if (tbl[i].g == 2'b10)
                chk($sformatf("row%0d m1 bus", i), {adr_o[11:0], dat_o[15:0], sel_o}, 32'hBCD44443);
            if (tbl[i].g != 2'b00)
                chk($sformatf("row%0d we", i), 32'(we_o), 32'(tbl[i].g == 2'b01));
            @(negedge clk);
        end
        chk("m0 dat passthrough", m0_dat_o, 32'hCAFE_F00D);

        set_in(9'b000_110_000);
        #1 chk("wdt idle grant", 32'(grant_o), 32'h0);
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk($sformatf("wdt c%0d grant", i), 32'(grant_o), 32'h2);
            chk($sformatf("wdt c%0d m1_err", i), 32'(m1_err), 32'(i == 8));
            chk($sformatf("wdt c%0d timeout", i), 32'(timeout_o), 32'(i == 8));
            @(negedge clk);
        end
        ack_i = 1'b1;
        #1;
        chk("abort grant", 32'(grant_o), 32'h2);
        chk("abort cyc/stb", 32'({cyc_o, stb_o}), 32'h0);
        chk("abort m1 terms", 32'({m1_ack, m1_err, m1_rty, timeout_o}), 32'h0);
        chk("abort tcnt", 32'(timeout_cnt_o), 32'h1);
        @(negedge clk);
        set_in(9'b000_000_000);
        #1 chk("abort hold grant", 32'(grant_o), 32'h2);
        @(negedge clk);
        #1 chk("abort exit grant", 32'(grant_o), 32'h0);

        set_in(9'b110_000_000);
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            ack_i = i == 8;
            #1;
            chk($sformatf("lim c%0d m0_ack", i), 32'(m0_ack), 32'(i == 8));
            chk($sformatf("lim c%0d m0_err", i), 32'({m0_err, timeout_o}), 32'h0);
            @(negedge clk);
        end
        ack_i = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            #1 chk($sformatf("post-ack c%0d err", i), 32'({m0_err, timeout_o, grant_o}), 32'h1);
            @(negedge clk);
        end
        set_in(9'b000_000_000);
        #1;
        chk("lim tcnt", 32'(timeout_cnt_o), 32'h1);
        chk("lim release grant", 32'(grant_o), 32'h1);
        @(negedge clk);
        #1 chk("lim idle grant", 32'(grant_o), 32'h0);

        set_in(9'b110_000_000);
        @(negedge clk);
        #1 chk("pre-reset cyc", 32'({cyc_o, stb_o}), 32'h3);
        #2;
        ack_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async reset cyc/stb", 32'({cyc_o, stb_o}), 32'h0);
        chk("async reset grant", 32'(grant_o), 32'h0);
        chk("async reset m0_ack", 32'(m0_ack), 32'h0);
        chk("async reset tcnt", 32'(timeout_cnt_o), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        set_in(9'b110_110_000);
        #1 chk("post-reset idle", 32'(grant_o), 32'h0);
        @(negedge clk);
        #1 chk("post-reset m0 first", 32'(grant_o), 32'h1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
